// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle shared by the MEM stage, the DMA engine and
// the data memory, as seen around dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [3:0]        dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: takes requests, drives the memory port.
    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_gnt, dma_rdata, dma_done,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    // Requester/memory side.
    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_gnt, dma_rdata, dma_done,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU owns the port by default, a burst
// DMA requester gets it when the CPU is idle or after a bounded wait.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          len_q, len_d;
    logic                we_q, we_d;

    logic                cpu_active;
    logic                last_beat;
    logic                grant;
    logic [3:0]          len_eff;
    logic [ADDR_W-1:0]   beat_addr;

    assign cpu_active = bus.cpu_read | bus.cpu_write;
    assign last_beat  = (beat_cnt_q == (len_q - 4'd1));
    assign beat_addr  = base_q + ADDR_W'({beat_cnt_q, 2'b00});

    // Normalise the requested length: zero means one beat, cap at BURST_MAX.
    always_comb begin
        len_eff = bus.dma_len;
        unique case (1'b1)
            (bus.dma_len == 4'd0): len_eff = 4'd1;
            (bus.dma_len >  BMAX): len_eff = BMAX;
            default:               len_eff = bus.dma_len;
        endcase
    end

    // Grant when the CPU leaves the port free, or when starvation runs out.
    assign grant = bus.dma_req &
                   (~cpu_active | (wait_cnt_q == WAIT_LAST));

    // Next-state, counter and burst-parameter computation.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        base_d     = base_q;
        len_d      = len_q;
        we_d       = we_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d    = BURST;
                    base_d     = bus.dma_addr;
                    len_d      = len_eff;
                    we_d       = bus.dma_we;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                end else if (bus.dma_req) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            BURST: begin
                if (!bus.dma_req || last_beat) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            base_q     <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            base_q     <= base_d;
            len_q      <= len_d;
            we_q       <= we_d;
        end
    end

    // Port steering: decoded from state/counters only, never from dma_req.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_read  = bus.cpu_read;
        bus.mem_write = bus.cpu_write;
        bus.cpu_stall = 1'b0;
        bus.dma_gnt   = 1'b0;
        bus.dma_done  = 1'b0;
        if (state_q == BURST) begin
            bus.mem_addr  = beat_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_read  = ~we_q;
            bus.mem_write = we_q;
            bus.cpu_stall = cpu_active;
            bus.dma_gnt   = 1'b1;
            bus.dma_done  = last_beat;
        end
    end

    // Read data goes straight through to whichever side owns the port.
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle table, latency sequence and a
// randomized run against a queue-based reference model.
module tb_dmem_arbiter;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32),
        .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Data memory: combinational read, write on the rising edge.
    logic [31:0] mem_arr [1024];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'hC0DE0000 | i;
        end else if (bus.mem_write) begin
            mem_arr[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem_arr[bus.mem_addr[11:2]];

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] caddr;
        logic        req, we;
        logic [31:0] daddr;
        logic [3:0]  len;
        logic [31:0] dw;
        logic        g, d, s;
        logic [31:0] ea;
        logic        er, ew;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(
        input logic rst, input logic rd, input logic wr,
        input logic [31:0] caddr, input logic req, input logic we,
        input logic [31:0] daddr, input logic [3:0] len,
        input logic [31:0] dw, input logic g, input logic d,
        input logic s, input logic [31:0] ea, input logic er,
        input logic ew);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.caddr = caddr;
        v.req = req; v.we = we; v.daddr = daddr; v.len = len;
        v.dw = dw; v.g = g; v.d = d; v.s = s; v.ea = ea;
        v.er = er; v.ew = ew;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] caddr, input logic [31:0] cw,
                         input logic req, input logic we,
                         input logic [31:0] daddr, input logic [3:0] len,
                         input logic [31:0] dw);
        reset         = rst;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cw;
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = daddr;
        bus.dma_len   = len;
        bus.dma_wdata = dw;
    endtask

    function automatic logic [31:0] cw_of(input logic [31:0] a);
        return a ^ 32'h5A5A5A5A;
    endfunction

    // Reference model state.
    logic        m_burst;
    logic        m_we;
    int          starve;
    logic [31:0] beats[$];

    initial begin
        int lat, nb, n;
        logic rd, wr, req, we, prev_done, rst;
        logic [31:0] caddr, cw, daddr, dw;
        logic [3:0] len;
        logic e_done;
        logic [31:0] ea;

        mem_clear = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        reset = 1'b0;

        // reset with contention
        add(1,1,0,'h40, 1,0,'h100,4,0, 0,0,0,'h40,1,0);
        add(1,1,0,'h40, 1,0,'h100,4,0, 0,0,0,'h40,1,0);
        add(0,0,0,'h44, 0,0,0,0,0,     0,0,0,'h44,0,0);
        // idle grant, write burst of 4
        add(0,0,0,'h48, 1,1,'h100,4,0, 0,0,0,'h48,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,'h48, 1,1,'h100,4,i,
                1,(i==3),0,32'h100 + 4*i,0,1);
        add(0,0,0,'h48, 0,0,0,0,0,     0,0,0,'h48,0,0);
        // forced grant under continuous CPU loads
        for (int i = 0; i < 4; i++)
            add(0,1,0,'h80, 1,0,'h200,2,0, 0,0,0,'h80,1,0);
        add(0,1,0,'h80, 1,0,'h200,2,0, 1,0,1,'h200,1,0);
        add(0,1,0,'h80, 1,0,'h200,2,0, 1,1,1,'h204,1,0);
        add(0,1,0,'h80, 0,0,0,0,0,     0,0,0,'h80,1,0);
        // len 0 -> one beat
        add(0,0,0,'h0, 1,0,'h300,0,0,  0,0,0,'h0,0,0);
        add(0,0,0,'h0, 1,0,'h300,0,0,  1,1,0,'h300,1,0);
        add(0,0,0,'h0, 0,0,0,0,0,      0,0,0,'h0,0,0);
        // len 15 -> clamped to 8, CPU store stalled meanwhile
        add(0,0,0,'h0, 1,0,'h300,15,0, 0,0,0,'h0,0,0);
        for (int i = 0; i < 8; i++)
            add(0,0,1,'hC0, 1,0,'h300,15,0,
                1,(i==7),1,32'h300 + 4*i,1,0);
        add(0,0,1,'hC0, 0,0,0,0,0,     0,0,0,'hC0,0,1);
        // abort: req drops during beat 2 of 6
        add(0,0,0,'h0, 1,1,'h400,6,'hA0, 0,0,0,'h0,0,0);
        add(0,0,0,'h0, 1,1,'h400,6,'hA0, 1,0,0,'h400,0,1);
        add(0,0,0,'h0, 1,1,'h400,6,'hA1, 1,0,0,'h404,0,1);
        add(0,0,0,'h0, 0,1,'h400,6,'hA2, 1,0,0,'h408,0,1);
        // wait counter restarted from zero after the abort
        for (int i = 0; i < 4; i++)
            add(0,1,0,'h84, 1,0,'h500,1,0, 0,0,0,'h84,1,0);
        add(0,1,0,'h84, 1,0,'h500,1,0, 1,1,1,'h500,1,0);
        add(0,1,0,'h84, 0,0,0,0,0,     0,0,0,'h84,1,0);
        // address wrap, full burst
        add(0,0,0,'h0, 1,0,'hFFFFFFF8,4,0, 0,0,0,'h0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,'h0, 1,0,'hFFFFFFF8,4,0,
                1,(i==3),0,32'hFFFFFFF8 + 4*i,1,0);
        add(0,0,0,'h0, 0,0,0,0,0,      0,0,0,'h0,0,0);
        // wrap again, reset at beat 2
        add(0,0,0,'h0, 1,0,'hFFFFFFF8,4,0, 0,0,0,'h0,0,0);
        add(0,0,0,'h0, 1,0,'hFFFFFFF8,4,0, 1,0,0,'hFFFFFFF8,1,0);
        add(0,0,0,'h0, 1,0,'hFFFFFFF8,4,0, 1,0,0,'hFFFFFFFC,1,0);
        add(1,0,0,'h0, 1,0,'hFFFFFFF8,4,0, 1,0,0,'h0,1,0);
        add(0,0,0,'h10, 0,0,0,0,0,     0,0,0,'h10,0,0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(posedge clk);
            #1;
            drive(v.rst, v.rd, v.wr, v.caddr, cw_of(v.caddr),
                  v.req, v.we, v.daddr, v.len, v.dw);
            @(negedge clk);
            chk($sformatf("row%0d_gnt", i), 32'(bus.dma_gnt), 32'(v.g));
            chk($sformatf("row%0d_done", i), 32'(bus.dma_done), 32'(v.d));
            chk($sformatf("row%0d_stall", i), 32'(bus.cpu_stall), 32'(v.s));
            chk($sformatf("row%0d_addr", i), bus.mem_addr, v.ea);
            chk($sformatf("row%0d_rd", i), 32'(bus.mem_read), 32'(v.er));
            chk($sformatf("row%0d_wr", i), 32'(bus.mem_write), 32'(v.ew));
            chk($sformatf("row%0d_wdata", i), bus.mem_wdata,
                v.g ? v.dw : cw_of(v.caddr));
        end

        // Memory contents left by the directed rows.
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrburst_mem%0d", k), mem_arr[64 + k], k);
        for (int k = 0; k < 3; k++)
            chk($sformatf("abort_mem%0d", k), mem_arr[256 + k],
                32'hA0 + k);
        chk("abort_mem3_untouched", mem_arr[259], 32'hC0DE0000 | 259);
        chk("cpu_store_after_stall", mem_arr[48], cw_of(32'hC0));

        // Grant latency with the CPU continuously busy, then a 3-beat burst.
        @(posedge clk);
        #1;
        drive(0, 1, 0, 'h88, 0, 1, 0, 'h600, 3, 0);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dma_gnt) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("forced_latency", lat, MAX_WAIT);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.dma_gnt) nb++;
            if (bus.dma_done) break;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        chk("forced_beats", nb, 3);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        m_burst = 1'b0; m_we = 1'b0; starve = 0; beats.delete();
        rd = 0; wr = 0; req = 0; we = 0; caddr = 0; daddr = 0;
        len = 0; prev_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc == 0) || ($urandom_range(0, 199) == 0);
            if (!(m_burst && (rd || wr))) begin
                n = $urandom_range(0, 3);
                rd = (n == 1);
                wr = (n == 2);
                caddr = $urandom() & 32'hFFFF_FFFC;
            end
            cw = $urandom();
            dw = $urandom();
            if (prev_done) begin
                req = 0;
            end else if (req) begin
                if ($urandom_range(0, 15) == 0) req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                req = 1;
            end
            if (!req || !m_burst) begin
                if (!req) begin
                    we = $urandom_range(0, 1);
                    daddr = $urandom() & 32'hFFFF_FFFC;
                    len = 4'($urandom_range(0, 15));
                end
            end
            drive(rst, rd, wr, caddr, cw, req, we, daddr, len, dw);
            @(negedge clk);
            if (m_burst) begin
                ea = beats[0];
                e_done = (beats.size() == 1);
                chk("rnd_gnt", 32'(bus.dma_gnt), 1);
                chk("rnd_done", 32'(bus.dma_done), 32'(e_done));
                chk("rnd_stall", 32'(bus.cpu_stall), 32'(rd | wr));
                chk("rnd_addr", bus.mem_addr, ea);
                chk("rnd_rd", 32'(bus.mem_read), 32'(!m_we));
                chk("rnd_wr", 32'(bus.mem_write), 32'(m_we));
                if (m_we) chk("rnd_dwdata", bus.mem_wdata, dw);
                else chk("rnd_dma_rdata", bus.dma_rdata, mem_arr[ea[11:2]]);
            end else begin
                e_done = 1'b0;
                chk("rnd_gnt", 32'(bus.dma_gnt), 0);
                chk("rnd_done", 32'(bus.dma_done), 0);
                chk("rnd_stall", 32'(bus.cpu_stall), 0);
                chk("rnd_addr", bus.mem_addr, caddr);
                chk("rnd_rd", 32'(bus.mem_read), 32'(rd));
                chk("rnd_wr", 32'(bus.mem_write), 32'(wr));
                if (wr) chk("rnd_cwdata", bus.mem_wdata, cw);
                if (rd) chk("rnd_cpu_rdata", bus.cpu_rdata,
                            mem_arr[caddr[11:2]]);
            end
            prev_done = e_done && !rst;
            // Advance the model across the coming edge.
            if (rst) begin
                m_burst = 0;
                beats.delete();
                starve = 0;
            end else if (!m_burst) begin
                if (req) begin
                    if (!(rd || wr) || starve == MAX_WAIT - 1) begin
                        n = (len == 0) ? 1 :
                            (int'(len) > BURST_MAX) ? BURST_MAX : int'(len);
                        for (int k = 0; k < n; k++)
                            beats.push_back(daddr + 32'(4 * k));
                        m_we = we;
                        m_burst = 1;
                        starve = 0;
                    end else begin
                        starve++;
                    end
                end else begin
                    starve = 0;
                end
            end else begin
                void'(beats.pop_front());
                if (beats.size() == 0 || !req) begin
                    m_burst = 0;
                    beats.delete();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter sitting between the pipeline's MEM stage and the data memory, sharing the port with one burst-capable DMA requester. The CPU owns the port by default. A DMA request is granted when the CPU is idle, or forcibly after a bounded wait. While a DMA burst owns the port, the arbiter stalls the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, address width (byte addresses, word-aligned).
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, cycles a pending DMA request may be starved before a forced grant (≥1).
- `BURST_MAX`, 8, maximum beats per burst (≤15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_read`  in  1  MEM-stage load.
- `cpu_write`  in  1  MEM-stage store.
- `cpu_addr`  in  ADDR_W  MEM-stage address.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_rdata`  out  DATA_W  load data.
- `cpu_stall`  out  1  freeze pipeline; CPU must hold its request.
- `dma_req`  in  1  burst request; held high until `dma_done`.
- `dma_we`  in  1  1 = write burst, 0 = read burst; sampled at grant.
- `dma_addr`  in  ADDR_W  burst base address; sampled at grant.
- `dma_len`  in  4  beat count; sampled at grant. 0 is treated as 1; values >BURST_MAX are clamped to BURST_MAX.
- `dma_wdata`  in  DATA_W  write data for the current beat.
- `dma_gnt`  out  1  DMA owns the port; every granted cycle is one beat.
- `dma_rdata`  out  DATA_W  read data for the current beat.
- `dma_done`  out  1  one-cycle pulse coincident with the last beat.
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  to data memory.
- `mem_read`, `mem_write`  out  1  to data memory. Reads are combinational; writes commit on the rising edge.
- `mem_rdata`  in  DATA_W  from data memory.

## Operation
- State machine with two states:
  - IDLE: CPU owns the port.
  - BURST: DMA owns the port.
- Registers:
  - `wait_cnt` (0..MAX_WAIT).
  - `beat_cnt` (0..BURST_MAX-1).
  - Latched `base`, `len`, `we`.
- IDLE behaviour:
  - `mem_*` follow the `cpu_*` inputs. `cpu_rdata` = `mem_rdata`. `cpu_stall` = 0. `dma_gnt` = 0.
  - When `dma_req` is high and `cpu_read|cpu_write` is high, `wait_cnt` increments.
  - Transition to BURST at the next edge if `dma_req` is high and either:
    - the CPU is idle that cycle, or
    - `wait_cnt` == MAX_WAIT-1 while the CPU is active (forced grant).
  - On transition: latch `base`/`len`/`we`, clear `wait_cnt` and `beat_cnt`.
  - The CPU access in the transition cycle is still served.
  - When `dma_req` is low, `wait_cnt` clears.
- BURST behaviour:
  - `dma_gnt` = 1.
  - `mem_addr` = `base` + 4·`beat_cnt`, with wrap-around modulo 2^ADDR_W.
  - `mem_write` = `we`; `mem_read` = ~`we`; `mem_wdata` = `dma_wdata`.
  - `dma_rdata` = `mem_rdata`.
  - `cpu_stall` = `cpu_read|cpu_write`. `cpu_rdata` is don't-care. CPU requests in BURST are never issued to memory.
  - `beat_cnt` increments each cycle.
  - When `beat_cnt` == `len`-1: `dma_done` = 1, and the next state is IDLE with counters cleared.
- `dma_req` dropping mid-burst:
  - The current cycle's beat still executes. There is no `dma_done`.
  - The next state is IDLE with counters cleared.
- After `dma_done`, the DMA must deassert `dma_req` for at least one cycle. A request still high in the first IDLE cycle is treated as a new request.
- Outputs `dma_rdata` and `cpu_rdata` are combinational from `mem_rdata`. All other control outputs are decoded from state and counters only, with no combinational path from `dma_req`.

## Timing
- Reset (synchronous, takes effect at the edge where `reset`=1):
  - State = IDLE; all counters and latches = 0.
  - Hence `dma_gnt`=0, `dma_done`=0, `cpu_stall`=0, and `mem_*` follow the CPU.
  - A reset asserted mid-burst aborts it: no `dma_done`, and any write in that cycle still commits.
- Grant latency:
  - 1 cycle from `dma_req` with the CPU idle.
  - With the CPU continuously busy: the first beat occurs MAX_WAIT cycles after `dma_req` rises.
- A burst of N beats occupies exactly N cycles. `cpu_stall` spans exactly those cycles in which the CPU requests.
- Back-to-back bursts leave at least one IDLE cycle between them.
- Simultaneous `dma_req` rise and CPU access: the CPU is served first; `wait_cnt` becomes 1 at the next edge.

## Test plan
- Reset: assert `reset` for 2 cycles, with `dma_req`=1 and `cpu_read`=1. Required response: `dma_gnt`=0, `cpu_stall`=0, `mem_addr`=`cpu_addr` throughout.
- Idle grant, write burst: CPU idle; `dma_req`=1, `dma_we`=1, `dma_addr`=0x100, `dma_len`=4, `dma_wdata`=beat index. Required response: `dma_gnt` for exactly 4 cycles starting 1 cycle later, `mem_addr` = 0x100, 0x104, 0x108, 0x10C, and `dma_done` only on the 4th beat.
- Forced grant: `cpu_read`=1 every cycle, DMA read burst of `dma_len`=2 at 0x200. Required response: first beat in cycle 4 after the `dma_req` rise; `cpu_stall`=1 for exactly those 2 cycles; CPU loads resume at its held address afterwards.
- Length edges: `dma_len`=0 yields exactly one beat with `dma_done`; `dma_len`=15 is clamped to 8 beats.
- Abort: drop `dma_req` after beat 2 of 6. Required response: only beats 0–2 reach memory, no `dma_done`, state returns to IDLE, and `wait_cnt` is 0.
- Address wrap and mid-burst reset: base 0xFFFFFFF8, `len`=4 gives addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004. A reset asserted at beat 2 leaves `dma_gnt`=0 the next cycle.
